// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//   Multi-cycle control FSM for the 12-bit processor. Owns the PC, latches the
//   instruction word into an internal IR and spreads every instruction over
//   FETCH -> EXEC (-> WB for LOAD), asserting datapath strobes only in
//   EXEC/WB. Provides a start/halt handshake and a saturating count of
//   retired instructions.
//
//   Optional build macro: SEQ_SINGLE_STEP_EN
//     Adds input `step` and a PAUSE state entered after every retired
//     instruction; a `step` pulse resumes with the next FETCH.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin execution from IDLE or HALTED (ignored while busy)
//   step       in   (SEQ_SINGLE_STEP_EN only) leave PAUSE for the next FETCH
//   inst       in   instruction word read combinationally at `pc`
//   pc         out  instruction address
//   RF_we      out  register file write enable
//   M_we       out  data memory write enable
//   M_re       out  data memory read enable
//   D_re       out  display register load enable
//   rwSRC      out  register write source (0 = ALU, 1 = memory)
//   ALU_opcode out  ALU operation, 0 outside EXEC
//   r1, r2, rw out  register addresses decoded from IR
//   c1         out  data memory address decoded from IR
//   busy       out  high in FETCH/EXEC/WB
//   halted     out  high in HALTED
//   retired    out  completed-instruction count, saturating
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int PC_W  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [11:0]      inst,
    output logic [PC_W-1:0]  pc,
    output logic             RF_we,
    output logic             M_we,
    output logic             M_re,
    output logic             D_re,
    output logic             rwSRC,
    output logic [2:0]       ALU_opcode,
    output logic [2:0]       r1,
    output logic [2:0]       r2,
    output logic [2:0]       rw,
    output logic [3:0]       c1,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] OP_STORE   = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_AND     = 3'b100;
    localparam logic [2:0] OP_OR      = 3'b101;
    localparam logic [2:0] OP_DISPLAY = 3'b110;
    localparam logic [2:0] OP_HALT    = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
        ,
        S_PAUSE  = 3'd5
`endif
    } state_e;

    // State that follows a retired instruction.
`ifdef SEQ_SINGLE_STEP_EN
    localparam state_e RETIRE_NEXT = S_PAUSE;
`else
    localparam state_e RETIRE_NEXT = S_FETCH;
`endif

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [11:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    // Set on the first clock edge seen with reset released; a start that
    // arrives together with reset release is therefore not honoured.
    logic             armed_q;
    logic             retire;
    logic [2:0]       opcode;

    assign opcode = ir_q[11:9];

    // NOTE: state registers use non-blocking assignments and reset
    // asynchronously, so strobes decoded from state_q fall the moment reset
    // asserts, even in the middle of an instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            armed_q   <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case statement can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        retire     = 1'b0;
        RF_we      = 1'b0;
        M_we       = 1'b0;
        M_re       = 1'b0;
        D_re       = 1'b0;
        rwSRC      = 1'b0;
        ALU_opcode = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (start && armed_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = inst;
                // HALT is recognised straight from the fetched word and never
                // reaches EXEC, so it is not counted as retired.
                state_d = (inst[11:9] == OP_HALT) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_STORE:   M_we = 1'b1;
                    OP_LOAD:    M_re = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        RF_we      = 1'b1;
                        ALU_opcode = opcode;
                    end
                    OP_DISPLAY: D_re = 1'b1;
                    default:    ;
                endcase
                if (opcode == OP_LOAD) state_d = S_WB;
                else                   retire  = 1'b1;
            end
            S_WB: begin
                // Memory read is held through WB so the read data is stable
                // while the register file captures it.
                M_re   = 1'b1;
                RF_we  = 1'b1;
                rwSRC  = 1'b1;
                retire = 1'b1;
            end
            S_HALTED: begin
                if (start && armed_q) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            pc_d      = pc_q + 1'b1;   // wraps silently at the top of memory
            retired_d = (retired_q == '1) ? retired_q : retired_q + 1'b1;
            state_d   = RETIRE_NEXT;
        end
    end

    // Register fields are decoded continuously from IR; STORE/DISPLAY read
    // their source from the low field and LOAD writes the register named there.
    assign rw = (opcode == OP_LOAD) ? ir_q[2:0] : ir_q[8:6];
    assign r1 = (opcode == OP_STORE || opcode == OP_DISPLAY) ? ir_q[2:0] : ir_q[5:3];
    assign r2 = ir_q[2:0];
    assign c1 = ir_q[7:4];

    assign pc      = pc_q;
    assign retired = retired_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
    assign halted  = (state_q == S_HALTED);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Self-checking bench. Programs are loaded into a small instruction memory
//   and an instruction-level reference model expands them into the expected
//   cycle-by-cycle outputs (2 cycles per ALU/STORE/DISPLAY, 3 per LOAD, HALT
//   parks the machine). Random start pulses are injected while busy and must
//   be ignored. Build with +define+SEQ_SINGLE_STEP_EN to cover PAUSE/step.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int PC_W    = 3;
    localparam int CNT_W   = 8;
    localparam int DEPTH   = 1 << PC_W;
    localparam int RET_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [11:0]      inst;
    logic [PC_W-1:0]  pc;
    logic             RF_we, M_we, M_re, D_re, rwSRC;
    logic [2:0]       ALU_opcode, r1, r2, rw;
    logic [3:0]       c1;
    logic             busy, halted;
    logic [CNT_W-1:0] retired;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
    int               pause_len = -1;
`endif

    logic [11:0] mem [DEPTH];
    assign inst = mem[pc];

    always #5 clk = ~clk;

    multicycle_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .inst       (inst),
        .pc         (pc),
        .RF_we      (RF_we),
        .M_we       (M_we),
        .M_re       (M_re),
        .D_re       (D_re),
        .rwSRC      (rwSRC),
        .ALU_opcode (ALU_opcode),
        .r1         (r1),
        .r2         (r2),
        .rw         (rw),
        .c1         (c1),
        .busy       (busy),
        .halted     (halted),
        .retired    (retired)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit can_start = 1'b1;   // DUT known to sit in IDLE or HALTED

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for one clock cycle plus the inputs to drive in it.
    typedef struct {
        logic       busy;
        logic       halted;
        int         pc;
        int         ret;
        logic [4:0] strb;     // {RF_we, M_we, M_re, D_re, rwSRC}
        logic       chk_alu;
        logic [2:0] alu;
        logic       chk_fld;
        logic [12:0] fld;     // {rw, r1, r2, c1}
        logic       drv_start;
        logic       drv_step;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t rec(input logic b, input logic h, input int pcv, input int rv,
                                 input logic [4:0] s, input logic ca, input logic [2:0] a,
                                 input logic cf, input logic [12:0] f);
        exp_t e;
        e.busy = b; e.halted = h; e.pc = pcv; e.ret = rv; e.strb = s;
        e.chk_alu = ca; e.alu = a; e.chk_fld = cf; e.fld = f;
        e.drv_start = 1'b0; e.drv_step = 1'b0;
        return e;
    endfunction

    function automatic logic [12:0] fields_of(input logic [11:0] ins);
        logic [2:0] op, f_rw, f_r1;
        op   = ins[11:9];
        f_rw = (op == 3'd1) ? ins[2:0] : ins[8:6];
        f_r1 = (op == 3'd0 || op == 3'd6) ? ins[2:0] : ins[5:3];
        return {f_rw, f_r1, ins[2:0], ins[7:4]};
    endfunction

    function automatic logic [4:0] exec_strobes(input logic [2:0] op);
        case (op)
            3'd0:                   return 5'b01000;
            3'd1:                   return 5'b00100;
            3'd2, 3'd3, 3'd4, 3'd5: return 5'b10000;
            3'd6:                   return 5'b00010;
            default:                return 5'b00000;
        endcase
    endfunction

    // Expands the program in mem into at least ncyc expected cycles, starting
    // from the first FETCH at pc 0 with a zero retired count.
    task automatic build_trace(input int ncyc);
        int          p = 0;
        int          r = 0;
        logic [11:0] ins;
        logic [2:0]  op;
        logic [12:0] f;
        exp_t        e;
        exp_q.delete();
        while (exp_q.size() < ncyc) begin
            ins = mem[p];
            op  = ins[11:9];
            f   = fields_of(ins);
            e = rec(1'b1, 1'b0, p, r, 5'b0, 1'b1, 3'd0, 1'b0, 13'd0);
            e.drv_start = ($urandom_range(0, 3) == 0);
            exp_q.push_back(e);
            if (op == 3'd7) begin
                while (exp_q.size() < ncyc)
                    exp_q.push_back(rec(1'b0, 1'b1, p, r, 5'b0, 1'b1, 3'd0, 1'b1, f));
                break;
            end
            e = rec(1'b1, 1'b0, p, r, exec_strobes(op), (op >= 3'd2 && op <= 3'd5), op, 1'b1, f);
            e.drv_start = ($urandom_range(0, 3) == 0);
            exp_q.push_back(e);
            if (op == 3'd1) begin
                e = rec(1'b1, 1'b0, p, r, 5'b10101, 1'b1, 3'd0, 1'b1, f);
                e.drv_start = ($urandom_range(0, 3) == 0);
                exp_q.push_back(e);
            end
            p = (p + 1) % DEPTH;
            r = (r < RET_MAX) ? r + 1 : RET_MAX;
`ifdef SEQ_SINGLE_STEP_EN
            begin
                int len;
                len = (pause_len >= 0) ? pause_len : int'($urandom_range(0, 3));
                repeat (len) begin
                    e = rec(1'b0, 1'b0, p, r, 5'b0, 1'b1, 3'd0, 1'b1, f);
                    e.drv_start = ($urandom_range(0, 1) == 0);
                    exp_q.push_back(e);
                end
                e = rec(1'b0, 1'b0, p, r, 5'b0, 1'b1, 3'd0, 1'b1, f);
                e.drv_step = 1'b1;
                exp_q.push_back(e);
            end
`endif
        end
    endtask

    task automatic run_trace(input string name);
        exp_t e;
        foreach (exp_q[i]) begin
            e = exp_q[i];
            check($sformatf("%s busy@%0d", name, i),    32'(busy),    32'(e.busy));
            check($sformatf("%s halted@%0d", name, i),  32'(halted),  32'(e.halted));
            check($sformatf("%s pc@%0d", name, i),      32'(pc),      32'(e.pc));
            check($sformatf("%s retired@%0d", name, i), 32'(retired), 32'(e.ret));
            check($sformatf("%s strobes@%0d", name, i),
                  32'({RF_we, M_we, M_re, D_re, rwSRC}), 32'(e.strb));
            if (e.chk_alu)
                check($sformatf("%s alu@%0d", name, i), 32'(ALU_opcode), 32'(e.alu));
            if (e.chk_fld)
                check($sformatf("%s fields@%0d", name, i), 32'({rw, r1, r2, c1}), 32'(e.fld));
            start = e.drv_start;
`ifdef SEQ_SINGLE_STEP_EN
            step  = e.drv_step;
`endif
            @(posedge clk); #1;
        end
        start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step  = 1'b0;
`endif
        can_start = exp_q[exp_q.size() - 1].halted;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        can_start = 1'b1;
    endtask

    task automatic launch();
        if (!can_start) do_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_prog(input string name, input int ncyc);
        build_trace(ncyc);
        launch();
        run_trace(name);
    endtask

    initial begin
        start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step  = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] = 12'h000;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset busy",    32'(busy),    32'd0);
        check("reset halted",  32'(halted),  32'd0);
        check("reset pc",      32'(pc),      32'd0);
        check("reset retired", 32'(retired), 32'd0);
        check("reset strobes", 32'({RF_we, M_we, M_re, D_re, rwSRC}), 32'd0);
        check("reset alu",     32'(ALU_opcode), 32'd0);
        check("reset fields",  32'({rw, r1, r2, c1}), 32'd0);

        // start raised together with reset release must not launch execution
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_at_release busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("start_at_release idle", 32'(busy), 32'd0);

        // ADD rw=3 r1=2 r2=1, then HALT
        mem[0] = {3'b010, 3'd3, 3'd2, 3'd1};
        mem[1] = 12'hE00;
        run_prog("add_halt", 8);

        // LOAD rw=5 c1=3, then HALT
        mem[0] = 12'h235;
        mem[1] = 12'hE00;
        run_prog("load", 8);

        // STORE c1=A r1=6, DISPLAY r1=6, HALT
        mem[0] = 12'h0A6;
        mem[1] = 12'hC06;
        mem[2] = 12'hE00;
        run_prog("store_disp", 10);

        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 12'($urandom);
            run_prog($sformatf("rand%0d", k), 60);
        end

        // no HALT anywhere: pc wraps, retired climbs to saturation
        for (int i = 0; i < DEPTH; i++) mem[i] = {3'b010, 9'($urandom)};
        run_prog("wrap", 1200);

`ifdef SEQ_SINGLE_STEP_EN
        pause_len = 10;
        for (int i = 0; i < DEPTH; i++) mem[i] = {3'($urandom_range(2, 5)), 9'($urandom)};
        run_prog("single_step", 40);
        pause_len = -1;
`else
        // reset asserted during the WB cycle of a LOAD
        do_reset();
        mem[0] = {3'b010, 9'($urandom)};
        mem[1] = {3'b001, 9'($urandom)};
        launch();
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("midload pre RF_we", 32'(RF_we), 32'd1);
        check("midload pre M_re",  32'(M_re),  32'd1);
        check("midload pre pc",    32'(pc),    32'd1);
        reset = 1'b0;
        #1;
        check("midload RF_we",   32'(RF_we),   32'd0);
        check("midload M_re",    32'(M_re),    32'd0);
        check("midload rwSRC",   32'(rwSRC),   32'd0);
        check("midload pc",      32'(pc),      32'd0);
        check("midload retired", 32'(retired), 32'd0);
        check("midload busy",    32'(busy),    32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midload idle busy", 32'(busy), 32'd0);
        check("midload idle pc",   32'(pc),   32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
